afifo_rd_capture_buf: RTL
=========================

Name: afifo_rd_capture_buf

Overview:
- Synthesizable read-side capture unit for the async FIFO bench, clocked in the read domain.
- Samples every successful FIFO read (rinc && !rempty) and tags it with a sequence number.
- Buffers the tagged reads in a parametrised circular store and drains them over a valid/ready port to the HVL read monitor proxy.
- Counts dropped reads and underflow attempts, and can halt capture on overflow.

Parameters:
- DATA_WIDTH, 32, width of rdata.
- BUF_DEPTH, 16, capture buffer entries; must be a power of 2 and at least 2.
- SEQ_WIDTH, 16, width of sequence and statistics counters.
- STOP_ON_OVF, 0: 1 = enter HALT on the first drop; 0 = keep running and count drops.

Ports:
- rclk  in  1  read-domain clock; all logic on posedge.
- rrst  in  1  synchronous, active-high reset.
- cap_en  in  1  level enable for capture.
- clr_halt  in  1  one-cycle pulse that leaves HALT.
- rinc  in  1  FIFO read increment.
- rempty  in  1  FIFO empty flag.
- rdata  in  DATA_WIDTH  FIFO read data, valid in the same cycle as rinc.
- out_valid  out  1  buffered entry available.
- out_ready  in  1  consumer accepts the entry.
- out_data  out  DATA_WIDTH  captured data.
- out_seq  out  SEQ_WIDTH  sequence tag of the entry.
- level  out  $clog2(BUF_DEPTH)+1  current occupancy.
- drop_cnt  out  SEQ_WIDTH  reads lost to a full buffer.
- unf_cnt  out  SEQ_WIDTH  read attempts made while empty.
- halted  out  1  state is HALT.

Behaviour:
- Reset (rrst=1 at posedge): state IDLE; out_valid=0, out_data=0, out_seq=0, level=0, drop_cnt=0, unf_cnt=0, halted=0, write/read pointers and seq counter 0. Reset mid-operation discards all buffered entries.
- Events:
  - rd_evt = rinc && !rempty.
  - unf_evt = rinc && rempty.
  - pop = out_valid && out_ready.
- State machine:
  - IDLE -> RUN when cap_en=1.
  - RUN -> IDLE when cap_en=0. Buffered entries stay drainable.
  - RUN -> HALT on the first drop, only when STOP_ON_OVF=1.
  - HALT -> IDLE on clr_halt=1. HALT ignores cap_en. halted=1 only in HALT.
- Capture:
  - Only in RUN. rd_evt pushes {rdata, seq}; seq increments by 1 per rd_evt.
  - seq also increments on a dropped read, so consumers see gaps.
  - seq wraps modulo 2^SEQ_WIDTH.
  - rd_evt in IDLE or HALT is neither captured nor counted, and seq does not advance.
- Full boundary:
  - Push when level==BUF_DEPTH and no pop that cycle: entry discarded and drop_cnt+1.
  - Push and pop in the same cycle at full: push accepted, level unchanged, no drop.
- Empty boundary: pop only when out_valid=1. Simultaneous push and pop at level 1: the new entry appears on out_* the next cycle with out_valid held 1.
- Output timing:
  - First-word-fall-through with registered outputs. A push into an empty buffer gives out_valid=1 on the next posedge (1-cycle latency).
  - out_data/out_seq stay stable while out_valid=1 && out_ready=0.
- unf_cnt increments on unf_evt in any state except reset. Counters saturate at all-ones and do not wrap.
- level updates every cycle: +1 on push-only, -1 on pop-only, 0 otherwise.
- Pointers wrap at BUF_DEPTH. level distinguishes full from empty.

Optional Feature:
- Macro: AFIFO_RD_CAPTURE_TIMESTAMP_EN.
- Defined:
  - Adds output port out_ts, SEQ_WIDTH bits: a free-running rclk cycle counter, reset to 0, wrapping.
  - out_ts is sampled at push time and stored alongside data and seq. It follows the same stability rules as out_data.
- Undefined: no out_ts port, no timestamp storage, no cycle counter.

Test Plan:
- Reset then cap_en=1; 4 reads with rdata=0xA0..0xA3, out_ready=1 -> out_valid rises 1 cycle after the first read; out_seq=0,1,2,3 with matching data; level returns to 0.
- out_ready=0; 18 consecutive reads, BUF_DEPTH=16, STOP_ON_OVF=0 -> level=16, drop_cnt=2; drain yields seq 0..15 in order. Next read gets seq=18 (gap visible).
- Same as above with STOP_ON_OVF=1 -> halted=1 after read 17. Further reads are ignored and seq is frozen at 17. clr_halt -> IDLE, halted=0.
- Buffer full with out_ready=1 and rd_evt in the same cycle -> no drop; level stays 16; data order preserved.
- rinc=1 with rempty=1 for 3 cycles -> unf_cnt=3, no push. Assert rrst mid-drain -> out_valid=0, level=0 and all counters 0 the next cycle.
- With AFIFO_RD_CAPTURE_TIMESTAMP_EN: reads at cycles 5 and 9 after reset release -> out_ts=5, then 9.

Source files
------------

// File: rtl/afifo_rd_capture_buf_if.sv
// Drain-side valid/ready bus of the read capture buffer.
// AFIFO_RD_CAPTURE_TIMESTAMP_EN adds the out_ts field.
interface afifo_rd_capture_buf_if #(
   parameter int DATA_WIDTH = 32,
   parameter int SEQ_WIDTH  = 16
);
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic [SEQ_WIDTH-1:0]  out_seq;
`ifdef AFIFO_RD_CAPTURE_TIMESTAMP_EN
   logic [SEQ_WIDTH-1:0]  out_ts;
`endif

   modport master (
`ifdef AFIFO_RD_CAPTURE_TIMESTAMP_EN
      output out_ts,
`endif
      output out_valid, out_data, out_seq,
      input  out_ready
   );

   modport slave (
`ifdef AFIFO_RD_CAPTURE_TIMESTAMP_EN
      input  out_ts,
`endif
      input  out_valid, out_data, out_seq,
      output out_ready
   );
endinterface

// File: rtl/afifo_rd_capture_buf.sv
// Read-domain capture of successful FIFO reads into a tagged circular buffer with FWFT drain.
// Optional macro AFIFO_RD_CAPTURE_TIMESTAMP_EN stores a free-running cycle stamp per entry.
module afifo_rd_capture_buf #(
   parameter int DATA_WIDTH  = 32,
   parameter int BUF_DEPTH   = 16,
   parameter int SEQ_WIDTH   = 16,
   parameter int STOP_ON_OVF = 0
) (
   input  logic                         rclk,
   input  logic                         rrst,
   input  logic                         cap_en,
   input  logic                         clr_halt,
   input  logic                         rinc,
   input  logic                         rempty,
   input  logic [DATA_WIDTH-1:0]        rdata,
   afifo_rd_capture_buf_if.master       drain,
   output logic [$clog2(BUF_DEPTH):0]   level,
   output logic [SEQ_WIDTH-1:0]         drop_cnt,
   output logic [SEQ_WIDTH-1:0]         unf_cnt,
   output logic                         halted
);
   localparam int AW = $clog2(BUF_DEPTH);
   localparam int LW = AW + 1;
`ifdef AFIFO_RD_CAPTURE_TIMESTAMP_EN
   localparam int EW = DATA_WIDTH + 2 * SEQ_WIDTH;
`else
   localparam int EW = DATA_WIDTH + SEQ_WIDTH;
`endif

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;

   state_t            state_reg, state_next;
   logic              capture;
   logic [EW-1:0]     mem [BUF_DEPTH];
   logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg, rd_ptr_inc;
   logic [LW-1:0]     level_reg, level_next;
   logic [SEQ_WIDTH-1:0] seq_reg, drop_reg, unf_reg;
   logic              out_valid_reg;
   logic [EW-1:0]     out_entry_reg, push_entry;
   logic              rd_evt, unf_evt, pop, full, push_req, push, drop;

   assign rd_evt     = rinc && !rempty;
   assign unf_evt    = rinc && rempty;
   assign pop        = out_valid_reg && drain.out_ready;
   assign full       = (level_reg == LW'(BUF_DEPTH));
   assign push_req   = capture && rd_evt;
   // A pop frees the slot in the same cycle, so a push at full only drops without one.
   assign push       = push_req && (!full || pop);
   assign drop       = push_req && full && !pop;
   assign rd_ptr_inc = rd_ptr_reg + AW'(1);

`ifdef AFIFO_RD_CAPTURE_TIMESTAMP_EN
   logic [SEQ_WIDTH-1:0] ts_reg;

   always_ff @(posedge rclk) begin
      if (rrst) ts_reg <= '0;
      else      ts_reg <= ts_reg + SEQ_WIDTH'(1);
   end

   assign push_entry   = {rdata, seq_reg, ts_reg};
   assign drain.out_ts = out_entry_reg[SEQ_WIDTH-1:0];
`else
   assign push_entry   = {rdata, seq_reg};
`endif

   // FSM: state register
   always_ff @(posedge rclk) begin
      if (rrst) state_reg <= IDLE;
      else      state_reg <= state_next;
   end

   // FSM: next state; a drop takes precedence over cap_en falling
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (cap_en) state_next = RUN;
         RUN: begin
            if ((STOP_ON_OVF != 0) && drop) state_next = HALT;
            else if (!cap_en)               state_next = IDLE;
         end
         HALT:    if (clr_halt) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      capture = (state_reg == RUN);
      halted  = (state_reg == HALT);
   end

   always_comb begin
      level_next = level_reg;
      case ({push, pop})
         2'b10:   level_next = level_reg + LW'(1);
         2'b01:   level_next = level_reg - LW'(1);
         default: level_next = level_reg;
      endcase
   end

   always_ff @(posedge rclk) begin
      if (push) mem[wr_ptr_reg] <= push_entry;
   end

   // Output register holds the head entry; an incoming push bypasses the RAM when it becomes head.
   always_ff @(posedge rclk) begin
      if (rrst) begin
         out_valid_reg <= 1'b0;
         out_entry_reg <= '0;
      end else begin
         out_valid_reg <= (level_next != '0);
         if (push && (level_reg == '0 || (pop && level_reg == LW'(1))))
            out_entry_reg <= push_entry;
         else if (pop && level_reg > LW'(1))
            out_entry_reg <= mem[rd_ptr_inc];
      end
   end

   always_ff @(posedge rclk) begin
      if (rrst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
         seq_reg    <= '0;
         drop_reg   <= '0;
         unf_reg    <= '0;
      end else begin
         level_reg <= level_next;
         if (push)     wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (pop)      rd_ptr_reg <= rd_ptr_inc;
         if (push_req) seq_reg    <= seq_reg + SEQ_WIDTH'(1);
         if (drop && drop_reg != '1)   drop_reg <= drop_reg + SEQ_WIDTH'(1);
         if (unf_evt && unf_reg != '1) unf_reg  <= unf_reg + SEQ_WIDTH'(1);
      end
   end

   assign drain.out_valid = out_valid_reg;
   assign drain.out_data  = out_entry_reg[EW-1 -: DATA_WIDTH];
   assign drain.out_seq   = out_entry_reg[EW-DATA_WIDTH-1 -: SEQ_WIDTH];
   assign level           = level_reg;
   assign drop_cnt        = drop_reg;
   assign unf_cnt         = unf_reg;
endmodule
